regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the vectorial ASIP register file. It shares the register file's single write port between two write-back requesters: the ALU/vector unit (port A) and the memory load unit (port M). It uses round-robin arbitration and valid/ready handshakes, and drives regWrEnSc, regWrEnVec, regToWrite and dataIn from a registered output stage. An optional scoreboard tracks in-flight writes for every scalar and vector register, so issue logic can stall on RAW/WAW hazards.

---
 rtl/asip_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/asip_pkg.sv
// Shared definitions for the vectorial ASIP register file and its write-back path.
// Holds bank geometry, the address/data types, the write-back payload struct and
// the address-to-scoreboard-bit mapping.
package asip_pkg;

  localparam int unsigned registerSize     = 8;
  localparam int unsigned registerQuantity = 4;
  localparam int unsigned selectionBits    = 2;
  localparam int unsigned vectorSize       = 4;

  localparam int unsigned AddrW    = selectionBits + 1;
  localparam int unsigned DataW    = vectorSize * registerSize;
  localparam int unsigned BusyW    = 2 * registerQuantity;
  localparam int unsigned BusyIdxW = $clog2(BusyW);

  typedef logic [selectionBits:0]                   regAddr_t;
  typedef logic [vectorSize-1:0][registerSize-1:0]  vecData_t;
  typedef logic [BusyIdxW-1:0]                      busyIdx_t;

  // One write-back transaction as presented to the register file.
  typedef struct packed {
    regAddr_t addr;
    vecData_t data;
  } wb_req_t;

  // Vector register i -> bit i, scalar register i -> bit registerQuantity+i.
  function automatic busyIdx_t busyIdx(regAddr_t addr);
    logic [selectionBits-1:0] reg_num;
    reg_num = addr[selectionBits-1:0];
    if (addr[selectionBits]) begin
      return busyIdx_t'(registerQuantity + 32'(reg_num));
    end
    return busyIdx_t'(reg_num);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req_i[1:0] : requests (bit 0 = port A, bit 1 = port M)
//   gnt_o_c    : one-hot combinational grant, forced to 0 while in reset
// The priority bit favours A when clear and M when set; it flips to the
// loser after every grant so contention alternates, starting with A.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o_c
);

  logic prio_q, prio_d;

  // Grant selection and priority update.
  always_comb begin
    gnt_o_c = 2'b00;
    prio_d  = prio_q;
    if (rst_n) begin
      if (req_i[0] && (!req_i[1] || !prio_q)) begin
        gnt_o_c = 2'b01;
      end else if (req_i[1]) begin
        gnt_o_c = 2'b10;
      end
    end
    if (gnt_o_c[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o_c[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter sharing the register file's single write port between the
// ALU/vector unit (port A) and the memory load unit (port M).
//   clk, reset              : clock, async active-low reset
//   aValid/aReady/aAddr/aData : port A request, grant, address, data
//   mValid/mReady/mAddr/mData : port M request, grant, address, data
//   regWrEnSc, regWrEnVec   : registered bank write enables to regFile
//   regToWrite, dataIn      : registered address/data to regFile
//   rsvValid, rsvAddr       : destination reservation from issue
//   busy                    : registered pending-write flags
// Build option: WB_SCOREBOARD_EN builds the scoreboard; otherwise busy is 0
// and the reservation inputs are ignored.
module regfile_wb_arbiter
  import asip_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   aValid,
  output logic                   aReady,
  input  logic [selectionBits:0] aAddr,
  input  logic [DataW-1:0]       aData,
  input  logic                   mValid,
  output logic                   mReady,
  input  logic [selectionBits:0] mAddr,
  input  logic [DataW-1:0]       mData,
  output logic                   regWrEnSc,
  output logic                   regWrEnVec,
  output logic [selectionBits:0] regToWrite,
  output logic [DataW-1:0]       dataIn,
  input  logic                   rsvValid,
  input  logic [selectionBits:0] rsvAddr,
  output logic [BusyW-1:0]       busy
);

  logic [1:0] gnt_c;
  wb_req_t    req_q, req_d;
  logic       wr_sc_q, wr_sc_d;
  logic       wr_vec_q, wr_vec_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req_i   ({mValid, aValid}),
    .gnt_o_c (gnt_c)
  );

  assign aReady = gnt_c[0];
  assign mReady = gnt_c[1];

  // Output stage: winner's payload, or hold payload with enables dropped.
  always_comb begin
    req_d    = req_q;
    wr_sc_d  = 1'b0;
    wr_vec_d = 1'b0;
    if (gnt_c[0]) begin
      req_d.addr = aAddr;
      req_d.data = vecData_t'(aData);
    end else if (gnt_c[1]) begin
      req_d.addr = mAddr;
      req_d.data = vecData_t'(mData);
    end
    if (gnt_c != 2'b00) begin
      wr_sc_d  = req_d.addr[selectionBits];
      wr_vec_d = ~req_d.addr[selectionBits];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q    <= '0;
      wr_sc_q  <= 1'b0;
      wr_vec_q <= 1'b0;
    end else begin
      req_q    <= req_d;
      wr_sc_q  <= wr_sc_d;
      wr_vec_q <= wr_vec_d;
    end
  end

  assign regWrEnSc  = wr_sc_q;
  assign regWrEnVec = wr_vec_q;
  assign regToWrite = req_q.addr;
  assign dataIn     = req_q.data;

`ifdef WB_SCOREBOARD_EN
  logic [BusyW-1:0] busy_q, busy_d;

  // Strobe clears as regFile captures; a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_sc_q || wr_vec_q) begin
      busy_d[busyIdx(req_q.addr)] = 1'b0;
    end
    if (rsvValid) begin
      busy_d[busyIdx(rsvAddr)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unused_rsv;
  assign unused_rsv = ^{rsvValid, rsvAddr};
  assign busy       = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, m_valid, rsv_valid;
  logic [2:0]  a_addr, m_addr, rsv_addr;
  logic [31:0] a_data, m_data;
  logic        a_ready, m_ready;
  logic        wr_sc, wr_vec;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .aValid     (a_valid),
    .aReady     (a_ready),
    .aAddr      (a_addr),
    .aData      (a_data),
    .mValid     (m_valid),
    .mReady     (m_ready),
    .mAddr      (m_addr),
    .mData      (m_data),
    .regWrEnSc  (wr_sc),
    .regWrEnVec (wr_vec),
    .regToWrite (wr_addr),
    .dataIn     (wr_data),
    .rsvValid   (rsv_valid),
    .rsvAddr    (rsv_addr),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Transaction-level model: who won last, the write regFile sees this cycle,
  // and which registers still have a write outstanding.
  bit          last_was_a;
  bit          e_wr;
  logic [2:0]  e_addr;
  logic [31:0] e_data;
  bit          pending [8];
  bit          acc_a, acc_m;
  bit          sb_on;

  function automatic int reg_bit(input logic [2:0] a);
    return a[2] ? 4 + int'(a[1:0]) : int'(a[1:0]);
  endfunction

  task automatic reset_model();
    last_was_a = 1'b0;
    e_wr       = 1'b0;
    e_addr     = 3'd0;
    e_data     = 32'd0;
    foreach (pending[i]) pending[i] = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, advance the model, return at posedge+1.
  task automatic tick();
    bit         ga, gm;
    logic [7:0] exp_busy;
    if (!reset) reset_model();
    ga = reset && a_valid && (!m_valid || !last_was_a);
    gm = reset && m_valid && !ga;
    @(negedge clk);
    exp_busy = 8'd0;
    if (sb_on) foreach (pending[i]) exp_busy[i] = pending[i];
    check_eq("aReady", 32'(a_ready), 32'(ga));
    check_eq("mReady", 32'(m_ready), 32'(gm));
    check_eq("regWrEnSc", 32'(wr_sc), 32'(e_wr && e_addr[2]));
    check_eq("regWrEnVec", 32'(wr_vec), 32'(e_wr && !e_addr[2]));
    check_eq("regToWrite", 32'(wr_addr), 32'(e_addr));
    check_eq("dataIn", wr_data, e_data);
    check_eq("busy", 32'(busy), 32'(exp_busy));
    if (reset) begin
      if (e_wr) pending[reg_bit(e_addr)] = 1'b0;
      if (rsv_valid) pending[reg_bit(rsv_addr)] = 1'b1;
      e_wr = ga || gm;
      if (ga) begin
        e_addr = a_addr; e_data = a_data; last_was_a = 1'b1;
      end else if (gm) begin
        e_addr = m_addr; e_data = m_data; last_was_a = 1'b0;
      end
    end
    acc_a = ga;
    acc_m = gm;
    @(posedge clk);
    #1;
  endtask

  bit grants [$];

  initial begin
`ifdef WB_SCOREBOARD_EN
    sb_on = 1'b1;
`else
    sb_on = 1'b0;
`endif
    reset     = 1'b0;
    a_valid   = 1'b1; a_addr = 3'b011; a_data = 32'hDEADBEEF;
    m_valid   = 1'b0; m_addr = 3'd0;   m_data = 32'd0;
    rsv_valid = 1'b1; rsv_addr = 3'd5;
    reset_model();
    @(posedge clk); #1;
    tick();
    tick();
    rsv_valid = 1'b0;

    // First write after reset: vector register 3 from port A.
    reset = 1'b1;
    tick();
    check_eq("tp1_accept", 32'(acc_a), 32'd1);
    a_valid = 1'b0;
    check_eq("tp1_vec", 32'(wr_vec), 32'd1);
    check_eq("tp1_sc", 32'(wr_sc), 32'd0);
    check_eq("tp1_addr", 32'(wr_addr), 32'd3);
    check_eq("tp1_data", wr_data, 32'hDEADBEEF);

    // Scalar write from port M.
    m_valid = 1'b1; m_addr = 3'b100; m_data = 32'd4;
    tick();
    m_valid = 1'b0;
    check_eq("tp2_sc", 32'(wr_sc), 32'd1);
    check_eq("tp2_vec", 32'(wr_vec), 32'd0);
    check_eq("tp2_addr", 32'(wr_addr), 32'd4);
    check_eq("tp2_data", wr_data, 32'd4);
    tick();

    // Continuous contention must alternate A, M, A, M.
    a_valid = 1'b1; a_addr = 3'($urandom); a_data = $urandom;
    m_valid = 1'b1; m_addr = 3'($urandom); m_data = $urandom;
    repeat (4) begin
      tick();
      if (acc_a) begin grants.push_back(1'b0); a_addr = 3'($urandom); a_data = $urandom; end
      if (acc_m) begin grants.push_back(1'b1); m_addr = 3'($urandom); m_data = $urandom; end
    end
    a_valid = 1'b0; m_valid = 1'b0;
    check_eq("cont_count", 32'(grants.size()), 32'd4);
    foreach (grants[i]) check_eq($sformatf("cont_order%0d", i), 32'(grants[i]), 32'(i % 2));
    tick();

    // Scoreboard: reserve 7, write 7 clears it, reserve during strobe keeps it.
    rsv_valid = 1'b1; rsv_addr = 3'd7;
    tick();
    rsv_valid = 1'b0;
    check_eq("sb_set7", 32'(busy[7]), 32'(sb_on));
    a_valid = 1'b1; a_addr = 3'd7; a_data = 32'h00000077;
    tick();
    a_valid = 1'b0;
    check_eq("sb_strobe7", 32'(wr_sc), 32'd1);
    tick();
    check_eq("sb_clr7", 32'(busy[7]), 32'd0);
    rsv_valid = 1'b1;
    tick();
    rsv_valid = 1'b0;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    rsv_valid = 1'b1;
    tick();
    rsv_valid = 1'b0;
    check_eq("sb_setwins7", 32'(busy[7]), 32'(sb_on));

    // Reset in the strobe cycle drops the write.
    a_valid = 1'b1; a_addr = 3'd2; a_data = 32'h12345678;
    tick();
    a_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("rst_vec", 32'(wr_vec), 32'd0);
    check_eq("rst_sc", 32'(wr_sc), 32'd0);
    check_eq("rst_data", wr_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic with occasional resets.
    repeat (500) begin
      if (!a_valid && $urandom_range(0, 2) != 0) begin
        a_valid = 1'b1; a_addr = 3'($urandom); a_data = $urandom;
      end
      if (!m_valid && $urandom_range(0, 2) != 0) begin
        m_valid = 1'b1; m_addr = 3'($urandom); m_data = $urandom;
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_addr  = 3'($urandom);
      reset     = ($urandom_range(0, 99) != 0);
      tick();
      if (acc_a) a_valid = 1'b0;
      if (acc_m) m_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
